// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB-first, odd parity, stop.
// Consumes the glitch-filtered clock level/strobe and samples a synchronised data line on each fall.
module ps2_receiver #(
    parameter int unsigned TIMEOUT = 5000,
    parameter int unsigned TW      = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk_f,
    input  logic       ps2_clk_chg,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic          data_meta, data_s;
    logic          fall;
    logic          expired;
    logic [7:0]    sr;
    logic [2:0]    bitcnt;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          good_done, frame_bad, parity_bad;

    // The PS/2 data line is asynchronous; the idle level is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    assign fall    = ps2_clk_chg & ~ps2_clk_f;
    assign expired = (state != IDLE) && (to_cnt == '0) && !fall;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (expired) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_nxt = DATA;
                DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame outcome at the stop-bit fall; a bad stop bit masks any parity result.
    always_comb begin
        busy       = (state != IDLE);
        frame_bad  = (state == STOP) && fall && !data_s;
        parity_bad = (state == STOP) && fall && data_s && !par_ok;
        good_done  = (state == STOP) && fall && data_s && par_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr          <= '0;
            bitcnt      <= '0;
            par_ok      <= 1'b0;
            to_cnt      <= TW'(TIMEOUT - 1);
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            err_parity  <= parity_bad;
            err_frame   <= frame_bad;
            err_timeout <= expired;
            overrun     <= good_done && rx_valid && !rx_ack;

            if (fall || state == IDLE) to_cnt <= TW'(TIMEOUT - 1);
            else                       to_cnt <= to_cnt - TW'(1);

            if (fall) begin
                case (state)
                    IDLE:    bitcnt <= '0;
                    DATA: begin
                        sr     <= {data_s, sr[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY:  par_ok <= ^sr ^ data_s;
                    default: ;
                endcase
            end else if (expired) begin
                sr <= '0;
            end

            // A new good byte wins over a coincident ack so rx_valid stays set.
            if (good_done) begin
                rx_data  <= sr;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
